mod_addsub_pipe: RTL

- Pipelined modular add/subtract unit for NTT butterfly datapaths; computes (a ± b) mod q on WIDTH-bit operands.
- Stage 1 produces per-bit propagate/generate vectors. The ripple carry generator (g | p & cin per bit) is instantiated in stage 2, which forms the carry vector and raw sum. Stage 3 does the conditional modular correction.
- Valid/ready streaming on both sides; one result per cycle when not stalled.

---
 rtl/mod_addsub_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mod_addsub_pipe.sv
// Three-stage pipelined modular add/subtract: (a +/- b) mod q with valid/ready streaming.
// Optional range checking of operands against q is enabled by defining MODADDSUB_RANGE_CHK_EN.
module mod_addsub_pipe #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_err
);

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  logic             s1_valid;
  logic             s1_sub;
  logic             s1_cin;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;

  logic [WIDTH-1:0] c;
  logic             carry;
  logic [WIDTH-1:0] carry_in;
  logic [WIDTH-1:0] raw_c;

  logic             s2_valid;
  logic             s2_sub;
  logic             s2_co;
  logic [WIDTH-1:0] s2_raw;

  logic [WIDTH-1:0] corr_c;

  // All stages shift together; a full output held by the sink freezes the pipe.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign b_eff = in_sub ? ~in_b : in_b;

  // Stage 1: propagate/generate vectors
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sub   <= 1'b0;
      s1_cin   <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sub   <= in_sub;
      s1_cin   <= in_sub;
      s1_p     <= in_a ^ b_eff;
      s1_g     <= in_a & b_eff;
    end
  end

  // Ripple carry chain, one bit at a time
  always_comb begin
    c     = '0;
    carry = s1_cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      c[i]  = s1_g[i] | (s1_p[i] & carry);
      carry = c[i];
    end
  end

  assign carry_in = {c[WIDTH-2:0], s1_cin};
  assign raw_c    = s1_p ^ carry_in;

  // Stage 2: raw sum and carry-out
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sub   <= 1'b0;
      s2_co    <= 1'b0;
      s2_raw   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sub   <= s1_sub;
      s2_co    <= c[WIDTH-1];
      s2_raw   <= raw_c;
    end
  end

  // For subtraction co=0 signals a borrow; for addition co=1 means raw wrapped past 2^WIDTH.
  always_comb begin
    corr_c = s2_raw;
    if (s2_sub) begin
      if (!s2_co) corr_c = s2_raw + q;
    end else begin
      if (s2_co || (s2_raw >= q)) corr_c = s2_raw - q;
    end
  end

  // Stage 3: corrected result; out_r only updates on real beats
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) out_r <= corr_c;
    end
  end

`ifdef MODADDSUB_RANGE_CHK_EN
  logic bad_c;
  logic s1_bad;
  logic s2_bad;
  logic s3_bad;

  assign bad_c = (in_a >= q) || (in_b >= q);

  // Range flag rides along with its beat and sets a sticky error on transfer out
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_bad  <= 1'b0;
      s2_bad  <= 1'b0;
      s3_bad  <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (advance) begin
        s1_bad <= bad_c;
        s2_bad <= s1_bad;
        s3_bad <= s2_bad;
      end
      if (out_valid && out_ready && s3_bad) out_err <= 1'b1;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule
